alu_cmd_responder: RTL and testbench

ALU-side responder for the ALU_in command interface. It accepts op/a/b commands with a valid/ready handshake, executes them, and drives the ALU_out result interface (done pulse plus result). It is the synthesizable counterpart the ALU_in agent initiates against. It serves as the DUT stand-in and reference target in block and emulation benches.

---
 rtl/alu_cmd_responder.sv | 126 ++++++++++++
 tb/tb_alu_cmd_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_responder.sv
// Command-side ALU responder: accepts op/a/b on a valid/ready handshake and
// returns a one-cycle done pulse with a held result. Optional illegal-op error
// pulse enabled by defining ALU_RESP_ILLEGAL_OP_ERR_EN.
module alu_cmd_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_rst,
  input  logic                      valid,
  output logic                      ready,
  input  logic [2:0]                op,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic                      err
);

  localparam int RW = 2 * DATA_WIDTH;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_RST = 3'd7;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

  state_e                state;
  logic [3:0]            mul_cnt;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [RW-1:0]         a_ext;
  logic [RW-1:0]         b_ext;
  logic [RW-1:0]         simple_res;
  logic                  accept;

  assign accept = valid && ready;
  assign a_ext  = RW'(a);
  assign b_ext  = RW'(b);

  // NOTE: every output of always_comb gets a default first so no latch is inferred.
  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADD:  simple_res = a_ext + b_ext;
      OP_AND:  simple_res = a_ext & b_ext;
      OP_XOR:  simple_res = a_ext ^ b_ext;
      default: simple_res = '0;
    endcase
  end

  // NOTE: operand holding registers carry no reset; they are only read after a mul accept loads them.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && accept && op == OP_MUL) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || alu_rst) begin
      state   <= ST_IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      result  <= '0;
      mul_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_ADD, OP_AND, OP_XOR: begin
                result <= simple_res;
                done   <= 1'b1;
              end
              OP_MUL: begin
                mul_cnt <= MUL_LOAD;
                state   <= ST_MUL;
                ready   <= 1'b0;
              end
              OP_RST:  result <= '0;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          // Counter reaches 1 in the cycle before done, so done lands MUL_LATENCY after accept.
          if (mul_cnt == 4'd1) begin
            result  <= RW'(a_q) * RW'(b_q);
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= ST_IDLE;
            mul_cnt <= '0;
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_RESP_ILLEGAL_OP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || alu_rst) begin
      err <= 1'b0;
    end else begin
      err <= accept && (state == ST_IDLE) && (op == 3'd5 || op == 3'd6);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Directed self-checking bench for alu_cmd_responder (default parameters).
module tb_alu_cmd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_rst;
  logic        valid;
  logic        ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        done;
  logic [15:0] result;
  logic        err;

  int checks = 0;
  int errors = 0;

`ifdef ALU_RESP_ILLEGAL_OP_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  alu_cmd_responder #(.DATA_WIDTH(8), .MUL_LATENCY(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_rst (alu_rst),
    .valid   (valid),
    .ready   (ready),
    .op      (op),
    .a       (a),
    .b       (b),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs then reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb);
    valid = v;
    op    = o;
    a     = aa;
    b     = bb;
  endtask

  initial begin
    rst = 1'b1;
    alu_rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    step();
    step();
    check("rst_ready", 16'(ready), 16'd1);
    check("rst_done", 16'(done), 16'd0);
    check("rst_result", result, 16'h0000);
    check("rst_err", 16'(err), 16'd0);
    rst = 1'b0;

    // add with carry into bit 8
    drive(1'b1, 3'd1, 8'hFF, 8'h01);
    step();
    check("add_done", 16'(done), 16'd1);
    check("add_result", result, 16'h0100);
    check("add_ready", 16'(ready), 16'd1);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    step();
    check("add_done_t2", 16'(done), 16'd0);
    check("add_hold", result, 16'h0100);

    // mul; a pending add is held by the initiator while ready is low
    drive(1'b1, 3'd4, 8'hFF, 8'hFF);
    step();
    drive(1'b1, 3'd1, 8'h00, 8'h00);
    check("mul_ready_t1", 16'(ready), 16'd0);
    check("mul_done_t1", 16'(done), 16'd0);
    step();
    check("mul_ready_t2", 16'(ready), 16'd0);
    check("mul_done_t2", 16'(done), 16'd0);
    check("mul_hold_t2", result, 16'h0100);
    step();
    check("mul_done_t3", 16'(done), 16'd1);
    check("mul_result", result, 16'hFE01);
    check("mul_ready_t3", 16'(ready), 16'd1);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    check("held_add_done", 16'(done), 16'd1);
    check("held_add_result", result, 16'h0000);

    // back-to-back simple ops
    drive(1'b1, 3'd3, 8'hAA, 8'h0F);
    step();
    check("xor_done", 16'(done), 16'd1);
    check("xor_result", result, 16'h00A5);
    drive(1'b1, 3'd2, 8'hF0, 8'h3C);
    step();
    check("and_done", 16'(done), 16'd1);
    check("and_result", result, 16'h0030);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    step();
    check("b2b_idle_done", 16'(done), 16'd0);

    // mul aborted by alu_rst
    drive(1'b1, 3'd4, 8'h10, 8'h10);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    alu_rst = 1'b1;
    check("abort_done_t1", 16'(done), 16'd0);
    step();
    alu_rst = 1'b0;
    check("abort_done_t2", 16'(done), 16'd0);
    check("abort_result", result, 16'h0000);
    check("abort_ready", 16'(ready), 16'd1);
    for (int i = 3; i <= 5; i++) begin
      step();
      check($sformatf("abort_done_t%0d", i), 16'(done), 16'd0);
    end

    // add, illegal op, no_op, rst_op, add
    drive(1'b1, 3'd1, 8'h03, 8'h04);
    step();
    check("add7_done", 16'(done), 16'd1);
    check("add7_result", result, 16'h0007);
    drive(1'b1, 3'd5, 8'h55, 8'h66);
    step();
    check("illegal_err", 16'(err), 16'(ERR_EXP));
    check("illegal_done", 16'(done), 16'd0);
    check("illegal_result", result, 16'h0007);
    check("illegal_ready", 16'(ready), 16'd1);
    drive(1'b1, 3'd0, 8'h12, 8'h34);
    step();
    check("nop_err", 16'(err), 16'd0);
    check("nop_done", 16'(done), 16'd0);
    check("nop_result", result, 16'h0007);
    drive(1'b1, 3'd7, 8'h00, 8'h00);
    step();
    check("rstop_done", 16'(done), 16'd0);
    check("rstop_result", result, 16'h0000);
    drive(1'b1, 3'd1, 8'h01, 8'h01);
    step();
    check("add2_done", 16'(done), 16'd1);
    check("add2_result", result, 16'h0002);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    step();
    check("final_done", 16'(done), 16'd0);
    check("final_hold", result, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
